mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 The block SHALL have ports: in_valid in 1, EX-stage operation valid; div_mul_control in 4, one-hot {multu,mult,divu,div} as [3:0]; hi_lo_control in 2, {mtlo,mthi} as [1:0].
REQ-003 The block SHALL have ports: src1 in 32, rs value (dividend/multiplicand/mthi-mtlo data); src2 in 32, rt value (divisor/multiplier); flush in 1, exception/eret cancel.
REQ-004 The block SHALL have ports: in_ready out 1, operation can be accepted; busy out 1, mult/div in progress; done out 1, single-cycle completion pulse.
REQ-005 The block SHALL have ports: hi out 32, HI register; lo out 32, LO register (mfhi/mflo source).

Function
REQ-006 The FSM SHALL have states IDLE, MUL, DIV, DONE; accept = in_valid & in_ready & ~flush.
REQ-007 in_ready SHALL be 1 in IDLE and DONE and 0 in MUL and DIV; busy SHALL equal (state==MUL | state==DIV).
REQ-008 Control priority when several bits are set SHALL be div > divu > mult > multu > mthi/mtlo; a lower-priority op in the same cycle SHALL be ignored.
REQ-009 mthi/mtlo on accept SHALL write src1 into hi/lo at that edge; no state change. Both bits set SHALL write both registers.
REQ-010 mult/multu on accept at end of cycle T SHALL go to MUL; in T+1, the 64-bit signed/unsigned product of operands latched at T SHALL be computed; {hi,lo} SHALL be loaded at end of T+1; DONE with done=1 SHALL follow in T+2.
REQ-011 div/divu on accept SHALL latch |src1|, |src2| (unsigned: raw), the quotient sign (src1[31]^src2[31]) and remainder sign (src1[31]), clear a 5-bit counter, and enter DIV.
REQ-012 DIV SHALL perform one radix-2 restoring iteration per cycle for exactly 32 cycles (T+1..T+32); the counter SHALL wrap 31->0 on the final iteration.
REQ-013 At end of T+32, lo SHALL receive the sign-corrected quotient and hi the sign-corrected remainder; DONE with done=1 SHALL follow in T+33.
REQ-014 Divide by zero SHALL raise no exception, with lo=0xFFFFFFFF and hi=src1 for both div and divu.
REQ-015 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (two's-complement wrap).
REQ-016 DONE SHALL last exactly one cycle; an op accepted in DONE SHALL behave as if accepted in IDLE (back-to-back); otherwise the next state SHALL be IDLE.
REQ-017 flush SHALL take priority over everything: in MUL/DIV the op SHALL be abandoned with hi/lo unmodified, done SHALL not pulse, and the next state SHALL be IDLE; flush with in_valid SHALL accept nothing.
REQ-018 Operand inputs SHALL be ignored while busy; results SHALL depend only on values latched at accept.
REQ-019 hi/lo SHALL change only on mthi/mtlo accept, mult completion or div completion.

Reset
REQ-020 reset sampled high SHALL force state=IDLE, hi=0, lo=0, counter=0, done=0, busy=0, in_ready=1, overriding flush and in_valid.
REQ-021 reset asserted mid-division SHALL discard the operation with no done pulse.

Verification
REQ-022 mult with src1=0xFFFFFFFE, src2=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+2, done=1 in T+2; multu with the same operands -> hi=0x2, lo=0xFFFFFFFA.
REQ-023 div with src1=-7 (0xFFFFFFF9), src2=2 -> busy T+1..T+32, done at T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2.
REQ-024 divu 5/0 -> lo=0xFFFFFFFF, hi=5; div 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-025 div started, flush asserted at T+10 -> IDLE at T+11, hi/lo hold prior values, no done pulse; in_valid with mthi during busy -> ignored, hi unchanged.
REQ-026 A mult accepted in the DONE cycle of a div -> div results visible, then mult results at its own T+2; mthi and mtlo set together with src1=0x1234 -> hi=lo=0x1234 next cycle.

Source files
------------

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: single-cycle multiply, 32-cycle radix-2 restoring divide,
// and direct mthi/mtlo writes, with flush cancellation and a one-cycle done pulse.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  div_mul_control,
    input  logic [1:0]  hi_lo_control,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    op_a, op_b, rem;
    logic [CW-1:0]   count;
    logic            mul_signed, quot_neg, rem_neg;

    logic            accept, op_div, op_divu, op_mult, op_multu, start_div, start_mul;
    logic [W-1:0]    src1_abs, src2_abs;
    logic [W:0]      trial, diff;
    logic            ge, last_iter;
    logic [W-1:0]    rem_step, quot_step, quot_fix, rem_fix;
    logic [2*W-1:0]  a_ext, b_ext, product;

    assign op_div    = div_mul_control[0];
    assign op_divu   = div_mul_control[1];
    assign op_mult   = div_mul_control[2];
    assign op_multu  = div_mul_control[3];
    assign accept    = in_valid & in_ready & ~flush;
    assign start_div = accept & (op_div | op_divu);
    assign start_mul = accept & ~(op_div | op_divu) & (op_mult | op_multu);

    // Signed divide works on magnitudes; signs are reapplied at completion.
    assign src1_abs = (op_div & src1[W-1]) ? W'(-src1) : src1;
    assign src2_abs = (op_div & src2[W-1]) ? W'(-src2) : src2;

    // One restoring step: op_a shifts out dividend bits and shifts in quotient bits.
    assign trial     = {rem, op_a[W-1]};
    assign diff      = trial - {1'b0, op_b};
    assign ge        = ~diff[W];
    assign rem_step  = ge ? diff[W-1:0] : trial[W-1:0];
    assign quot_step = {op_a[W-2:0], ge};
    assign last_iter = (count == CW'(W - 1));

    // A zero divisor leaves an all-ones quotient regardless of sign.
    assign quot_fix = (op_b == '0) ? '1 : (quot_neg ? W'(-quot_step) : quot_step);
    assign rem_fix  = rem_neg ? W'(-rem_step) : rem_step;

    assign a_ext   = {{W{mul_signed & op_a[W-1]}}, op_a};
    assign b_ext   = {{W{mul_signed & op_b[W-1]}}, op_b};
    assign product = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE) || (state_nxt == DONE);
            busy     <= (state_nxt == MUL) || (state_nxt == DIV);
            done     <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start_div)      state_nxt = DIV;
                else if (start_mul) state_nxt = MUL;
            end
            MUL:     state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= '0;
            lo         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rem        <= '0;
            count      <= '0;
            mul_signed <= 1'b0;
            quot_neg   <= 1'b0;
            rem_neg    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_div) begin
                        op_a     <= src1_abs;
                        op_b     <= src2_abs;
                        rem      <= '0;
                        count    <= '0;
                        quot_neg <= op_div & (src1[W-1] ^ src2[W-1]);
                        rem_neg  <= op_div & src1[W-1];
                    end else if (start_mul) begin
                        op_a       <= src1;
                        op_b       <= src2;
                        mul_signed <= op_mult;
                    end else if (accept) begin
                        if (hi_lo_control[0]) hi <= src1;
                        if (hi_lo_control[1]) lo <= src1;
                    end
                end
                MUL: begin
                    if (!flush) {hi, lo} <= product;
                end
                DIV: begin
                    if (!flush) begin
                        op_a  <= quot_step;
                        rem   <= rem_step;
                        count <= CW'(count + CW'(1));
                        if (last_iter) begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a latency/arithmetic reference model checked every cycle,
// plus literal expectations for the documented corner cases.
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid, flush;
    logic [3:0]  div_mul_control;
    logic [1:0]  hi_lo_control;
    logic [31:0] src1, src2;
    logic        in_ready, busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .div_mul_control(div_mul_control), .hi_lo_control(hi_lo_control),
        .src1(src1), .src2(src2), .flush(flush),
        .in_ready(in_ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural result plus a remaining-cycle countdown.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_busy, m_done, checking_on;
    int          m_left, sa, sb;
    longint      sprod;
    logic [63:0] uprod;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_left = 0;
        end else if (m_busy) begin
            m_done = 0;
            if (flush) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (in_valid && !flush) begin
                if (div_mul_control[0] || div_mul_control[1]) begin
                    if (src2 == 32'd0) begin
                        p_lo = 32'hFFFF_FFFF; p_hi = src1;
                    end else if (div_mul_control[0]) begin
                        if (src1 == 32'h8000_0000 && src2 == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = 32'd0;
                        end else begin
                            sa = int'(src1); sb = int'(src2);
                            p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
                        end
                    end else begin
                        p_lo = src1 / src2; p_hi = src1 % src2;
                    end
                    m_left = 32; m_busy = 1;
                end else if (div_mul_control[2]) begin
                    sa = int'(src1); sb = int'(src2);
                    sprod = longint'(sa) * longint'(sb);
                    p_hi = sprod[63:32]; p_lo = sprod[31:0];
                    m_left = 1; m_busy = 1;
                end else if (div_mul_control[3]) begin
                    uprod = {32'd0, src1} * {32'd0, src2};
                    p_hi = uprod[63:32]; p_lo = uprod[31:0];
                    m_left = 1; m_busy = 1;
                end else begin
                    if (hi_lo_control[0]) m_hi = src1;
                    if (hi_lo_control[1]) m_lo = src1;
                end
            end
        end
        checking_on = 1;
    end

    always @(negedge clk) begin
        if (checking_on) begin
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_in_ready", 32'(in_ready), 32'(!m_busy));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    // Presents one op for a single cycle starting at the current negedge.
    task automatic issue(input logic [3:0] c, input logic [1:0] h,
                         input logic [31:0] a, input logic [31:0] b, input logic f);
        in_valid = 1'b1; div_mul_control = c; hi_lo_control = h;
        src1 = a; src2 = b; flush = f;
        @(negedge clk);
        in_valid = 1'b0; div_mul_control = '0; hi_lo_control = '0; flush = 1'b0;
        src1 = $urandom(); src2 = $urandom();
    endtask

    task automatic wait_done(input string name, input int exp);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        div_mul_control = '0; hi_lo_control = '0; src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(4'b0100, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done("mult_latency", 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(4'b1000, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_done("multu_latency", 1);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        repeat (2) @(negedge clk);

        issue(4'b0001, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_latency", 32);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        issue(4'b0100, 2'b00, 32'd7, 32'd6, 1'b0);
        wait_done("b2b_mult_latency", 1);
        check("b2b_mult_lo", lo, 32'd42);
        check("b2b_mult_hi", hi, 32'd0);
        @(negedge clk);

        issue(4'b0010, 2'b00, 32'd100, 32'd7, 1'b0);
        wait_done("divu_latency", 32);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        issue(4'b0010, 2'b00, 32'd5, 32'd0, 1'b0);
        wait_done("divu0_latency", 32);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd5);

        issue(4'b0001, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("divovf_latency", 32);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        issue(4'b0001, 2'b00, 32'hFFFF_FFF8, 32'd0, 1'b0);
        wait_done("div0neg_latency", 32);
        check("div0neg_lo", lo, 32'hFFFF_FFFF);
        check("div0neg_hi", hi, 32'hFFFF_FFF8);

        issue(4'b1101, 2'b11, 32'd20, 32'hFFFF_FFFD, 1'b0);
        wait_done("prio_div_latency", 32);
        check("prio_div_lo", lo, 32'hFFFF_FFFA);
        check("prio_div_hi", hi, 32'd2);

        issue(4'b1100, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("prio_mult_latency", 1);
        check("prio_mult_hi", hi, 32'd0);
        check("prio_mult_lo", lo, 32'd1);
        @(negedge clk);

        issue(4'b0000, 2'b11, 32'h0000_1234, 32'd0, 1'b0);
        check("mthilo_hi", hi, 32'h0000_1234);
        check("mthilo_lo", lo, 32'h0000_1234);
        check("mthilo_done", 32'(done), 32'd0);

        issue(4'b0001, 2'b00, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_lo", lo, 32'h0000_1234);
        repeat (40) @(negedge clk);

        issue(4'b0001, 2'b00, 32'd9, 32'd2, 1'b0);
        in_valid = 1'b1; hi_lo_control = 2'b01; src1 = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0; hi_lo_control = 2'b00;
        check("busy_mthi_hi", hi, 32'h0000_1234);
        wait_done("busy_div_latency", 31);
        check("busy_div_lo", lo, 32'd4);
        check("busy_div_hi", hi, 32'd1);
        @(negedge clk);

        issue(4'b0000, 2'b01, 32'h0000_5555, 32'd0, 1'b1);
        check("flush_mthi_hi", hi, 32'd1);

        issue(4'b0001, 2'b00, 32'd50, 32'd5, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_div_hi", hi, 32'd0);
        check("rst_div_lo", lo, 32'd0);
        check("rst_div_busy", 32'(busy), 32'd0);
        check("rst_div_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
